// File: rtl/pixel_feeder.sv
// pixel_feeder: front end of the fractal pipeline.
//
// Scans one frame in row-major order and issues one fresh pixel into the pipe
// input slot on every cycle that the recirculating pipeline leaves it free.
// Every issued word carries the pixel constant (c1 real, c2 imaginary), a
// zeroed iterate and iteration count, and the linear pixel address that tags
// the result downstream.
//
// Ports:
//   Clk        in   single clock, all state updates on the rising edge
//   Reset      in   asynchronous, active-high
//   Start      in   begin a frame; only looked at while idle
//   slot_busy  in   pipe input slot taken by a recirculating pixel this cycle
//   x, y       out  iterate seed (Q4.12), always zero on an issue
//   c1, c2     out  pixel constant (Q4.12)
//   div        out  iteration count seed, always zero on an issue
//   no_op      out  1 = bubble, the pipe ignores the word
//   stage      out  1 = fresh pixel entering stage 0
//   addr       out  linear pixel index (row * H_RES + col) of the issued word
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last pixel has been issued
module pixel_feeder #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19,
    parameter logic [15:0] X_MIN  = 16'hE000,
    parameter logic [15:0] Y_MAX  = 16'h1400,
    parameter logic [15:0] X_STEP = 16'h0013,
    parameter logic [15:0] Y_STEP = 16'h0015
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              slot_busy,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       c1,
    output logic [15:0]       c2,
    output logic [7:0]        div,
    output logic              no_op,
    output logic              stage,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Scan state
    logic [1:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [15:0]       next_c1_q, next_c1_d;
    logic [15:0]       next_c2_q, next_c2_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;

    // Registered outputs
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [15:0]       c1_q, c1_d;
    logic [15:0]       c2_q, c2_d;
    logic [7:0]        div_q, div_d;
    logic              no_op_q, no_op_d;
    logic              stage_q, stage_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        next_c1_d   = next_c1_q;
        next_c2_d   = next_c2_q;
        next_addr_d = next_addr_q;

        // Data outputs hold unless a pixel is issued; markers default to bubble.
        x_d     = x_q;
        y_d     = y_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        div_d   = div_q;
        addr_d  = addr_q;
        no_op_d = 1'b1;
        stage_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d     = ST_RUN;
                    col_d       = '0;
                    row_d       = '0;
                    next_c1_d   = X_MIN;
                    next_c2_d   = Y_MAX;
                    next_addr_d = '0;
                end
            end

            ST_RUN: begin
                if (!slot_busy) begin
                    x_d     = 16'h0000;
                    y_d     = 16'h0000;
                    c1_d    = next_c1_q;
                    c2_d    = next_c2_q;
                    div_d   = 8'h00;
                    addr_d  = next_addr_q;
                    no_op_d = 1'b0;
                    stage_d = 1'b1;

                    next_addr_d = next_addr_q + ADDR_W'(1);

                    if (col_q == COL_LAST) begin
                        // Reload the real part from X_MIN so rounding never
                        // accumulates from one row to the next.
                        col_d     = '0;
                        next_c1_d = X_MIN;
                        row_d     = row_q + ROW_W'(1);
                        next_c2_d = next_c2_q - Y_STEP;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        col_d     = col_q + COL_W'(1);
                        next_c1_d = next_c1_q + X_STEP;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy stays high through the done pulse so it drops one edge later.
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            next_c1_q   <= 16'h0000;
            next_c2_q   <= 16'h0000;
            next_addr_q <= '0;
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            c1_q        <= 16'h0000;
            c2_q        <= 16'h0000;
            div_q       <= 8'h00;
            no_op_q     <= 1'b1;
            stage_q     <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            next_c1_q   <= next_c1_d;
            next_c2_q   <= next_c2_d;
            next_addr_q <= next_addr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            div_q       <= div_d;
            no_op_q     <= no_op_d;
            stage_q     <= stage_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign c1    = c1_q;
    assign c2    = c2_q;
    assign div   = div_q;
    assign no_op = no_op_q;
    assign stage = stage_q;
    assign addr  = addr_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// Bench for pixel_feeder: small 4x3 frame, behavioural pixel model, random
// stalls and stray Start pulses, mid-frame async reset, and a second instance
// whose X_MIN/X_STEP force a two's-complement wrap of c1.
module tb_pixel_feeder;

    localparam int          H    = 4;
    localparam int          V    = 3;
    localparam int          N    = H * V;
    localparam logic [15:0] XMIN = 16'hE000;
    localparam logic [15:0] YMAX = 16'h1000;
    localparam logic [15:0] XS   = 16'h0400;
    localparam logic [15:0] YS   = 16'h0800;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        slot_busy;
    logic [15:0] x, y, c1, c2;
    logic [7:0]  div;
    logic        no_op, stage, busy, done;
    logic [3:0]  addr;

    // Wrap-check instance
    logic        w_sb;
    logic [15:0] w_x, w_y, w_c1, w_c2;
    logic [7:0]  w_div;
    logic        w_no_op, w_stage, w_busy, w_done;
    logic [3:0]  w_addr;

    always #5 Clk = ~Clk;

    pixel_feeder #(
        .H_RES(H), .V_RES(V), .ADDR_W(4),
        .X_MIN(XMIN), .Y_MAX(YMAX), .X_STEP(XS), .Y_STEP(YS)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .slot_busy(slot_busy),
        .x(x), .y(y), .c1(c1), .c2(c2), .div(div), .no_op(no_op), .stage(stage),
        .addr(addr), .busy(busy), .done(done)
    );

    pixel_feeder #(
        .H_RES(H), .V_RES(V), .ADDR_W(4),
        .X_MIN(16'h7F00), .Y_MAX(YMAX), .X_STEP(16'h0100), .Y_STEP(YS)
    ) dut_wrap (
        .Clk(Clk), .Reset(Reset), .Start(Start), .slot_busy(w_sb),
        .x(w_x), .y(w_y), .c1(w_c1), .c2(w_c2), .div(w_div), .no_op(w_no_op),
        .stage(w_stage), .addr(w_addr), .busy(w_busy), .done(w_done)
    );

    int total = 0;
    int bad   = 0;

    // Model: frame progress expressed as a pixel index plus a done-pending flag.
    bit          m_run;
    int          m_idx;
    bit          m_tail;
    logic [15:0] e_c1, e_c2;
    logic [3:0]  e_addr;
    logic        e_noop, e_stage, e_busy, e_done;

    int          issued_cnt;
    int          done_cnt;
    logic [15:0] got_c1 [N];
    logic [15:0] got_c2 [N];
    logic [3:0]  got_addr [N];
    logic [15:0] w_c1_col1, w_c1_col2;
    bit          w_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_idx  = 0;
        m_tail = 1'b0;
        e_c1   = 16'h0000;
        e_c2   = 16'h0000;
        e_addr = 4'h0;
        e_noop = 1'b1;
        e_stage = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sb);
        e_done = 1'b0;
        if (m_run) begin
            e_busy = 1'b1;
            if (!sb) begin
                e_c1    = XMIN + 16'(m_idx % H) * XS;
                e_c2    = YMAX - 16'(m_idx / H) * YS;
                e_addr  = 4'(m_idx);
                e_noop  = 1'b0;
                e_stage = 1'b1;
                m_idx++;
                if (m_idx == N) begin
                    m_run  = 1'b0;
                    m_tail = 1'b1;
                end
            end else begin
                e_noop  = 1'b1;
                e_stage = 1'b0;
            end
        end else if (m_tail) begin
            m_tail  = 1'b0;
            e_done  = 1'b1;
            e_busy  = 1'b1;
            e_noop  = 1'b1;
            e_stage = 1'b0;
        end else begin
            e_noop  = 1'b1;
            e_stage = 1'b0;
            e_busy  = st;
            if (st) begin
                m_run = 1'b1;
                m_idx = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("x",     32'(x),     32'h0);
        chk("y",     32'(y),     32'h0);
        chk("div",   32'(div),   32'h0);
        chk("c1",    32'(c1),    32'(e_c1));
        chk("c2",    32'(c2),    32'(e_c2));
        chk("addr",  32'(addr),  32'(e_addr));
        chk("no_op", 32'(no_op), 32'(e_noop));
        chk("stage", 32'(stage), 32'(e_stage));
        chk("busy",  32'(busy),  32'(e_busy));
        chk("done",  32'(done),  32'(e_done));
    endtask

    task automatic step(input logic st, input logic sb);
        Start     = st;
        slot_busy = sb;
        @(posedge Clk);
        model_edge(st, sb);
        #1;
        compare_all();
        if (stage === 1'b1 && issued_cnt < N) begin
            got_c1[issued_cnt]   = c1;
            got_c2[issued_cnt]   = c2;
            got_addr[issued_cnt] = addr;
            issued_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (!w_seen && w_stage === 1'b1) begin
            if (w_addr == 4'd1) w_c1_col1 = w_c1;
            if (w_addr == 4'd2) begin
                w_c1_col2 = w_c1;
                w_seen    = 1'b1;
            end
        end
    endtask

    // mode 0: never stall; 1: stall on issue cycles 3 and 4; 2: random stalls.
    task automatic run_frame(input int mode, input bit start_noise);
        int k;
        bit sb;
        bit st;
        issued_cnt = 0;
        done_cnt   = 0;
        step(1'b1, 1'b0);
        k = 0;
        while ((m_run || m_tail) && k < 200) begin
            k++;
            case (mode)
                1:       sb = (k == 3 || k == 4);
                2:       sb = ($urandom_range(0, 2) == 0);
                default: sb = 1'b0;
            endcase
            st = start_noise && m_run && ($urandom_range(0, 3) == 0);
            step(st, sb);
        end
        chk("frame_ends", 32'(m_run || m_tail), 32'h0);
        step(1'b0, 1'b0);
        chk("frame_issues", 32'(issued_cnt), 32'(N));
        chk("frame_done_pulses", 32'(done_cnt), 32'h1);
        for (int i = 0; i < N; i++) chk("issue_order", 32'(got_addr[i]), 32'(i));
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        slot_busy = 1'b0;
        w_sb      = 1'b0;
        w_seen    = 1'b0;
        w_c1_col1 = 16'h0;
        w_c1_col2 = 16'h0;
        issued_cnt = 0;
        done_cnt   = 0;
        model_reset();
        #12;
        compare_all();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // Frame 1: no stalls
        run_frame(0, 1'b0);
        chk("lit_c1_col0", 32'(got_c1[0]),  32'hE000);
        chk("lit_c1_col3", 32'(got_c1[3]),  32'hEC00);
        chk("lit_c2_row1", 32'(got_c2[5]),  32'h0800);
        chk("lit_c2_row2", 32'(got_c2[11]), 32'h0000);
        chk("lit_c1_row2", 32'(got_c1[10]), 32'hE800);
        chk("wrap_col1", 32'(w_c1_col1), 32'h8000);
        chk("wrap_col2", 32'(w_c1_col2), 32'h8100);

        // Frame 2: two bubbles, resume at addr 2
        run_frame(1, 1'b0);
        chk("lit_resume_addr", 32'(got_addr[2]), 32'h2);
        chk("lit_resume_c1",   32'(got_c1[2]),   32'hE800);

        // Frames with random stalls and Start while busy
        for (int f = 0; f < 4; f++) run_frame(2, 1'b1);

        // Mid-frame asynchronous reset at addr 6
        issued_cnt = 0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 40 && !(e_stage && e_addr == 4'd6); k++) step(1'b0, 1'b0);
        chk("reached_addr6", 32'(addr), 32'h6);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_no_op", 32'(no_op), 32'h1);
        chk("async_stage", 32'(stage), 32'h0);
        chk("async_busy",  32'(busy),  32'h0);
        chk("async_addr",  32'(addr),  32'h0);
        chk("async_c1",    32'(c1),    32'h0);
        chk("async_c2",    32'(c2),    32'h0);
        model_reset();
        @(posedge Clk);
        #1;
        compare_all();
        Reset = 1'b0;
        step(1'b0, 1'b0);

        run_frame(0, 1'b0);
        chk("restart_c1",   32'(got_c1[0]),   32'hE000);
        chk("restart_c2",   32'(got_c2[0]),   32'h1000);
        chk("restart_addr", 32'(got_addr[0]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
